// File: rtl/exu_redirect_ctrl_pkg.sv
// exu_redirect_ctrl_pkg
//   Shared types and constants for the EX-stage redirect controller.
//   - XLEN        : architectural address width used on all PC/target ports.
//   - DRAIN_CNT_W : width of the wrong-path drain counter (holds 0..15).
//   - redir_st_e  : redirect FSM state encoding (idle / request / drain).
package exu_redirect_ctrl_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned DRAIN_CNT_W = 4;

    typedef enum logic [1:0] {
        RedirStIdle  = 2'd0,
        RedirStReq   = 2'd1,
        RedirStDrain = 2'd2
    } redir_st_e;

endpackage

// File: rtl/exu_redirect_drain_cnt.sv
// exu_redirect_drain_cnt
//   Loadable down-counter with a zero flag, used to time the wrong-path drain
//   window after the IFU accepts a redirect.
//   Ports:
//     i_clk      clock
//     i_rstn     synchronous active-low reset (counter clears to 0)
//     i_load     load i_load_val (takes priority over i_dec)
//     i_load_val value to load
//     i_dec      decrement by one; ignored when already zero
//     o_zero     counter currently holds zero
module exu_redirect_drain_cnt
    import exu_redirect_ctrl_pkg::*;
#(
    parameter int unsigned W = DRAIN_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/exu_redirect_ctrl.sv
// exu_redirect_ctrl
//   Sequences redirects from the branch/jump unit and from traps to the fetch
//   unit. A redirect is latched, offered to the IFU on a valid/ready handshake
//   while EX is stalled and IF/ID are flushed, then the front end keeps being
//   flushed for DRAIN_CYCLES cycles after acceptance. Resolved conditional
//   branches seen in idle are reported back to the branch predictor.
//   Optional feature: define EXU_MISPRED_CNT_EN to add o_mispred_cnt, a
//   wrapping count of BJU redirects taken from idle (traps not counted).
//   Ports:
//     i_clk, i_rstn                       clock, synchronous active-low reset
//     i_bju_vld/isbxx/taken/jaddr/iaddr/bflag
//                                         BJU result for the EX instruction
//     i_trap_req, i_trap_addr             trap redirect request and vector
//     o_redir_vld, o_redir_addr, i_redir_rdy
//                                         redirect handshake to the IFU
//     o_flush                             flush IF/ID pipeline registers
//     o_exu_stall                         hold EX stage
//     o_bpu_upd_vld/pc/taken              predictor update (1-cycle strobe)
//     o_mispred_cnt                       mispredict count (macro only)
module exu_redirect_ctrl
    import exu_redirect_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_bju_vld,
    input  logic            i_bju_isbxx,
    input  logic            i_bju_taken,
    input  logic [XLEN-1:0] i_bju_jaddr,
    input  logic [XLEN-1:0] i_bju_iaddr,
    input  logic            i_bju_bflag,
    input  logic            i_trap_req,
    input  logic [XLEN-1:0] i_trap_addr,
    output logic            o_redir_vld,
    output logic [XLEN-1:0] o_redir_addr,
    input  logic            i_redir_rdy,
    output logic            o_flush,
    output logic            o_exu_stall,
    output logic            o_bpu_upd_vld,
    output logic [XLEN-1:0] o_bpu_upd_pc,
    output logic            o_bpu_upd_taken
`ifdef EXU_MISPRED_CNT_EN
    ,
    output logic [CNT_W-1:0] o_mispred_cnt
`endif
);

    if ((DRAIN_CYCLES < 1) || (DRAIN_CYCLES > 15)) begin : g_bad_drain_cycles
        $error("DRAIN_CYCLES must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    localparam logic [DRAIN_CNT_W-1:0] DrainLoad = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    redir_st_e       state_q;
    redir_st_e       state_d;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] addr_d;
    logic            drain_load;
    logic            drain_dec;
    logic            drain_zero;
    logic            bpu_upd;
    logic            bpu_upd_vld_q;
    logic [XLEN-1:0] bpu_upd_pc_q;
    logic            bpu_upd_taken_q;

    exu_redirect_drain_cnt #(
        .W (DRAIN_CNT_W)
    ) u_drain_cnt (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_load     (drain_load),
        .i_load_val (DrainLoad),
        .i_dec      (drain_dec),
        .o_zero     (drain_zero)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= RedirStIdle;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and arbitration
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        drain_load = 1'b0;
        drain_dec  = 1'b0;
        bpu_upd    = 1'b0;
        unique case (state_q)
            RedirStIdle: begin
                if (i_trap_req) begin
                    // Trap wins; the BJU result in EX is discarded with it.
                    state_d = RedirStReq;
                    addr_d  = i_trap_addr;
                end else begin
                    if (i_bju_vld && i_bju_taken) begin
                        state_d = RedirStReq;
                        addr_d  = i_bju_jaddr;
                    end
                    bpu_upd = i_bju_vld && i_bju_isbxx;
                end
            end
            RedirStReq: begin
                if (i_trap_req) begin
                    // A trap replaces the pending target and the request stays
                    // up, even if the old target was accepted this same cycle.
                    addr_d = i_trap_addr;
                end else if (i_redir_rdy) begin
                    state_d    = RedirStDrain;
                    drain_load = 1'b1;
                end
            end
            RedirStDrain: begin
                if (i_trap_req) begin
                    state_d = RedirStReq;
                    addr_d  = i_trap_addr;
                end else if (drain_zero) begin
                    state_d = RedirStIdle;
                end else begin
                    drain_dec = 1'b1;
                end
            end
            default: begin
                state_d = RedirStIdle;
            end
        endcase
    end

    // Outputs decode the registered state only, so they are glitch-free
    always_comb begin
        o_redir_vld  = (state_q == RedirStReq);
        o_exu_stall  = (state_q == RedirStReq);
        o_flush      = (state_q == RedirStReq) || (state_q == RedirStDrain);
        o_redir_addr = addr_q;
    end

    // Predictor update: strobe for one cycle, payload held until next update
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            bpu_upd_vld_q   <= 1'b0;
            bpu_upd_pc_q    <= '0;
            bpu_upd_taken_q <= 1'b0;
        end else begin
            bpu_upd_vld_q <= bpu_upd;
            if (bpu_upd) begin
                bpu_upd_pc_q    <= i_bju_iaddr;
                // BJU flags a redirect when the prediction was wrong, so the
                // real direction is the predicted one flipped by that flag.
                bpu_upd_taken_q <= i_bju_bflag ^ i_bju_taken;
            end
        end
    end

    assign o_bpu_upd_vld   = bpu_upd_vld_q;
    assign o_bpu_upd_pc    = bpu_upd_pc_q;
    assign o_bpu_upd_taken = bpu_upd_taken_q;

`ifdef EXU_MISPRED_CNT_EN
    logic [CNT_W-1:0] mispred_cnt_q;
    logic             mispred_inc;

    assign mispred_inc = (state_q == RedirStIdle) && !i_trap_req && i_bju_vld && i_bju_taken;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mispred_cnt_q <= '0;
        end else if (mispred_inc) begin
            mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
module tb_exu_redirect_ctrl;

    logic        clk;
    logic        rstn;
    logic        bju_vld;
    logic        bju_isbxx;
    logic        bju_taken;
    logic [31:0] bju_jaddr;
    logic [31:0] bju_iaddr;
    logic        bju_bflag;
    logic        trap_req;
    logic [31:0] trap_addr;
    logic        redir_vld;
    logic [31:0] redir_addr;
    logic        redir_rdy;
    logic        flush;
    logic        exu_stall;
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic        upd_taken;
`ifdef EXU_MISPRED_CNT_EN
    logic [31:0] mispred_cnt;
    logic [31:0] exp_cnt;
`endif

    int vectors;
    int miscompares;

    exu_redirect_ctrl #(
        .DRAIN_CYCLES (2),
        .CNT_W        (32)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_bju_vld       (bju_vld),
        .i_bju_isbxx     (bju_isbxx),
        .i_bju_taken     (bju_taken),
        .i_bju_jaddr     (bju_jaddr),
        .i_bju_iaddr     (bju_iaddr),
        .i_bju_bflag     (bju_bflag),
        .i_trap_req      (trap_req),
        .i_trap_addr     (trap_addr),
        .o_redir_vld     (redir_vld),
        .o_redir_addr    (redir_addr),
        .i_redir_rdy     (redir_rdy),
        .o_flush         (flush),
        .o_exu_stall     (exu_stall),
        .o_bpu_upd_vld   (upd_vld),
        .o_bpu_upd_pc    (upd_pc),
        .o_bpu_upd_taken (upd_taken)
`ifdef EXU_MISPRED_CNT_EN
        ,
        .o_mispred_cnt   (mispred_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bju_vld   = 1'b0;
        bju_isbxx = 1'b0;
        bju_taken = 1'b0;
        bju_jaddr = 32'h0;
        bju_iaddr = 32'h0;
        bju_bflag = 1'b0;
        trap_req  = 1'b0;
        trap_addr = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        redir_rdy = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        vectors++; if (redir_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %0b expected 0", redir_vld); end
        vectors++; if (redir_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", redir_addr); end
        vectors++; if ({flush, exu_stall, upd_vld, upd_taken} !== 4'b0) begin miscompares++; $display("FAIL reset_ctl: got %b expected 0000", {flush, exu_stall, upd_vld, upd_taken}); end
        vectors++; if (upd_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", upd_pc); end
`ifdef EXU_MISPRED_CNT_EN
        exp_cnt = 32'd0;
        vectors++; if (mispred_cnt !== exp_cnt) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", mispred_cnt); end
`endif
        rstn = 1'b1;
        tick();
    endtask

    // Redirect accepted immediately: REQ one cycle, then two DRAIN cycles.
    task automatic test_bju_redirect();
        redir_rdy = 1'b1;
        bju_vld   = 1'b1;
        bju_taken = 1'b1;
        bju_jaddr = 32'h8000_0100;
        tick();
        clear_inputs();
        vectors++; if (redir_vld !== 1'b1) begin miscompares++; $display("FAIL bju_vld: got %0b expected 1", redir_vld); end
        vectors++; if (redir_addr !== 32'h8000_0100) begin miscompares++; $display("FAIL bju_addr: got %h expected 80000100", redir_addr); end
        vectors++; if ({flush, exu_stall} !== 2'b11) begin miscompares++; $display("FAIL bju_req_ctl: got %b expected 11", {flush, exu_stall}); end
        vectors++; if (upd_vld !== 1'b0) begin miscompares++; $display("FAIL bju_no_upd: got %0b expected 0", upd_vld); end
`ifdef EXU_MISPRED_CNT_EN
        exp_cnt = exp_cnt + 1;
        vectors++; if (mispred_cnt !== exp_cnt) begin miscompares++; $display("FAIL bju_cnt: got %0d expected %0d", mispred_cnt, exp_cnt); end
`endif
        tick();
        vectors++; if ({redir_vld, flush, exu_stall} !== 3'b010) begin miscompares++; $display("FAIL bju_drain1: got %b expected 010", {redir_vld, flush, exu_stall}); end
        tick();
        vectors++; if ({redir_vld, flush, exu_stall} !== 3'b010) begin miscompares++; $display("FAIL bju_drain2: got %b expected 010", {redir_vld, flush, exu_stall}); end
        tick();
        vectors++; if ({redir_vld, flush, exu_stall} !== 3'b000) begin miscompares++; $display("FAIL bju_idle: got %b expected 000", {redir_vld, flush, exu_stall}); end
    endtask

    // IFU holds off for 5 cycles; a BJU redirect arriving while stalled is ignored.
    task automatic test_backpressure();
        redir_rdy = 1'b0;
        bju_vld   = 1'b1;
        bju_taken = 1'b1;
        bju_jaddr = 32'h8000_0300;
        tick();
        bju_jaddr = 32'h8000_0ABC;
        for (int i = 0; i < 5; i++) begin
            vectors++; if ({redir_vld, exu_stall, flush} !== 3'b111) begin miscompares++; $display("FAIL bp_hold_%0d: got %b expected 111", i, {redir_vld, exu_stall, flush}); end
            vectors++; if (redir_addr !== 32'h8000_0300) begin miscompares++; $display("FAIL bp_addr_%0d: got %h expected 80000300", i, redir_addr); end
            if (i == 4) begin
                clear_inputs();
                redir_rdy = 1'b1;
            end
            tick();
        end
`ifdef EXU_MISPRED_CNT_EN
        exp_cnt = exp_cnt + 1;
        vectors++; if (mispred_cnt !== exp_cnt) begin miscompares++; $display("FAIL bp_cnt: got %0d expected %0d", mispred_cnt, exp_cnt); end
`endif
        vectors++; if ({redir_vld, flush, exu_stall} !== 3'b010) begin miscompares++; $display("FAIL bp_drain: got %b expected 010", {redir_vld, flush, exu_stall}); end
        tick();
        tick();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got %0b expected 0", flush); end
    endtask

    task automatic test_trap_bju_simul();
        redir_rdy = 1'b1;
        trap_req  = 1'b1;
        trap_addr = 32'h8000_0004;
        bju_vld   = 1'b1;
        bju_isbxx = 1'b1;
        bju_taken = 1'b1;
        bju_jaddr = 32'h8000_0200;
        bju_iaddr = 32'h0000_0444;
        tick();
        clear_inputs();
        vectors++; if (redir_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL simul_addr: got %h expected 80000004", redir_addr); end
        vectors++; if (redir_vld !== 1'b1) begin miscompares++; $display("FAIL simul_vld: got %0b expected 1", redir_vld); end
        vectors++; if (upd_vld !== 1'b0) begin miscompares++; $display("FAIL simul_no_upd: got %0b expected 0", upd_vld); end
`ifdef EXU_MISPRED_CNT_EN
        vectors++; if (mispred_cnt !== exp_cnt) begin miscompares++; $display("FAIL simul_cnt: got %0d expected %0d", mispred_cnt, exp_cnt); end
`endif
        repeat (3) tick();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL simul_idle: got %0b expected 0", flush); end
    endtask

    task automatic test_trap_during_req();
        redir_rdy = 1'b0;
        bju_vld   = 1'b1;
        bju_taken = 1'b1;
        bju_jaddr = 32'h8000_0200;
        tick();
        clear_inputs();
`ifdef EXU_MISPRED_CNT_EN
        exp_cnt = exp_cnt + 1;
`endif
        vectors++; if (redir_addr !== 32'h8000_0200) begin miscompares++; $display("FAIL treq_first: got %h expected 80000200", redir_addr); end
        trap_req  = 1'b1;
        trap_addr = 32'h8000_0004;
        tick();
        clear_inputs();
        vectors++; if (redir_addr !== 32'h8000_0004) begin miscompares++; $display("FAIL treq_addr: got %h expected 80000004", redir_addr); end
        vectors++; if (redir_vld !== 1'b1) begin miscompares++; $display("FAIL treq_vld: got %0b expected 1", redir_vld); end
        redir_rdy = 1'b1;
        tick();
        vectors++; if ({redir_vld, flush} !== 2'b01) begin miscompares++; $display("FAIL treq_drain: got %b expected 01", {redir_vld, flush}); end
        // Trap arriving in DRAIN reopens the request with the new vector.
        trap_req  = 1'b1;
        trap_addr = 32'h0000_1000;
        tick();
        clear_inputs();
        vectors++; if ({redir_vld, exu_stall} !== 2'b11) begin miscompares++; $display("FAIL tdrain_req: got %b expected 11", {redir_vld, exu_stall}); end
        vectors++; if (redir_addr !== 32'h0000_1000) begin miscompares++; $display("FAIL tdrain_addr: got %h expected 00001000", redir_addr); end
        repeat (3) tick();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL tdrain_idle: got %0b expected 0", flush); end
`ifdef EXU_MISPRED_CNT_EN
        vectors++; if (mispred_cnt !== exp_cnt) begin miscompares++; $display("FAIL treq_cnt: got %0d expected %0d", mispred_cnt, exp_cnt); end
`endif
    endtask

    task automatic test_branch_update();
        // Correctly predicted taken branch: no redirect, update says taken.
        bju_vld   = 1'b1;
        bju_isbxx = 1'b1;
        bju_bflag = 1'b1;
        bju_taken = 1'b0;
        bju_iaddr = 32'h0000_0080;
        tick();
        clear_inputs();
        vectors++; if (redir_vld !== 1'b0) begin miscompares++; $display("FAIL cp_no_redir: got %0b expected 0", redir_vld); end
        vectors++; if ({upd_vld, upd_taken} !== 2'b11) begin miscompares++; $display("FAIL cp_upd: got %b expected 11", {upd_vld, upd_taken}); end
        vectors++; if (upd_pc !== 32'h0000_0080) begin miscompares++; $display("FAIL cp_pc: got %h expected 00000080", upd_pc); end
        tick();
        vectors++; if (upd_vld !== 1'b0) begin miscompares++; $display("FAIL cp_strobe: got %0b expected 0", upd_vld); end
        // Predicted taken but actually not taken: redirect plus update not-taken.
        redir_rdy = 1'b1;
        bju_vld   = 1'b1;
        bju_isbxx = 1'b1;
        bju_bflag = 1'b1;
        bju_taken = 1'b1;
        bju_iaddr = 32'h0000_0C40;
        bju_jaddr = 32'h0000_0C44;
        tick();
        clear_inputs();
`ifdef EXU_MISPRED_CNT_EN
        exp_cnt = exp_cnt + 1;
`endif
        vectors++; if ({redir_vld, upd_vld, upd_taken} !== 3'b110) begin miscompares++; $display("FAIL mp_upd: got %b expected 110", {redir_vld, upd_vld, upd_taken}); end
        vectors++; if ({upd_pc, redir_addr} !== {32'h0000_0C40, 32'h0000_0C44}) begin miscompares++; $display("FAIL mp_addrs: got %h expected 00000c4000000c44", {upd_pc, redir_addr}); end
        repeat (3) tick();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL mp_idle: got %0b expected 0", flush); end
    endtask

    task automatic test_reset_mid_req();
        redir_rdy = 1'b0;
        bju_vld   = 1'b1;
        bju_taken = 1'b1;
        bju_jaddr = 32'h8000_0500;
        tick();
        clear_inputs();
        vectors++; if (redir_vld !== 1'b1) begin miscompares++; $display("FAIL rm_pre: got %0b expected 1", redir_vld); end
        rstn = 1'b0;
        tick();
        vectors++; if ({redir_vld, flush, exu_stall, upd_vld, upd_taken} !== 5'b0) begin miscompares++; $display("FAIL rm_ctl: got %b expected 00000", {redir_vld, flush, exu_stall, upd_vld, upd_taken}); end
        vectors++; if ({redir_addr, upd_pc} !== 64'h0) begin miscompares++; $display("FAIL rm_data: got %h expected 0", {redir_addr, upd_pc}); end
`ifdef EXU_MISPRED_CNT_EN
        vectors++; if (mispred_cnt !== 32'h0) begin miscompares++; $display("FAIL rm_cnt: got %0d expected 0", mispred_cnt); end
`endif
        rstn = 1'b1;
        redir_rdy = 1'b1;
        tick();
        vectors++; if ({redir_vld, flush} !== 2'b00) begin miscompares++; $display("FAIL rm_discard: got %b expected 00", {redir_vld, flush}); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        redir_rdy   = 1'b1;
        clear_inputs();
        test_reset();
        test_bju_redirect();
        test_backpressure();
        test_trap_bju_simul();
        test_trap_during_req();
        test_branch_update();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
